// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_stage
//  Description : Instruction fetch unit with IF/ID pipeline register. Issues
//                in-order requests to instruction memory (one outstanding),
//                honours stall/flush/redirect from the hazard unit and uses
//                a one-entry skid buffer for responses landing during a
//                Decode stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            StallFetch,
   input  logic            StallDecode,
   input  logic            FlushDecode,
   input  logic            ProgramCounterSourceExec,
   input  logic [XLEN-1:0] BranchTargetExec,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic [XLEN-1:0] InstrDec,
   output logic [XLEN-1:0] PCDec,
   output logic [XLEN-1:0] PCPlus4Dec,
   output logic            ValidDec
);

   // FETCH: idle, WAIT: response wanted, DRAIN: response to be dropped
   typedef enum logic [1:0] {
      c_fetch = 2'd0,
      c_wait  = 2'd1,
      c_drain = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] c_four = XLEN'(4);

   state_t          r_state;
   state_t          w_state_next;
   logic [XLEN-1:0] r_pc_f;
   logic [XLEN-1:0] r_req_pc;
   logic            r_skid_valid;
   logic [XLEN-1:0] r_skid_instr;
   logic [XLEN-1:0] r_skid_pc;

   logic w_redirect;
   logic w_skid_empty;
   logic w_rsp_direct;
   logic w_rsp_take;
   logic w_load_rsp;
   logic w_fill_skid;
   logic w_drain_skid;
   logic w_req_fire;

   assign w_redirect   = ProgramCounterSourceExec;
   assign w_skid_empty = ~r_skid_valid;
   assign w_rsp_direct = ~StallDecode & w_skid_empty;

   // A response in WAIT is kept unless a redirect kills it in the same cycle
   assign w_rsp_take   = (r_state == c_wait) & imem_rsp_valid & ~w_redirect;
   assign w_load_rsp   = w_rsp_take & w_rsp_direct;
   assign w_fill_skid  = w_rsp_take & ~w_rsp_direct;

   // Skid content is wrong-path on a redirect, so it is dropped, never loaded
   assign w_drain_skid = r_skid_valid & ~StallDecode & ~w_redirect;

   // Back-to-back issue is only allowed when the returning word can go
   // straight into IF/ID, which keeps the single skid entry sufficient
   assign imem_req_valid = rst_n & ~StallFetch & ~w_redirect & w_skid_empty &
                           ((r_state == c_fetch) |
                            ((r_state == c_wait) & imem_rsp_valid & w_rsp_direct));
   assign imem_req_addr  = r_pc_f;
   assign w_req_fire     = imem_req_valid & imem_req_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_fetch;
      else        r_state <= w_state_next;
   end

   // Next-state logic; unused encoding falls back to FETCH
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_fetch: begin
            if (w_req_fire) w_state_next = c_wait;
         end
         c_wait: begin
            if (w_redirect)          w_state_next = imem_rsp_valid ? c_fetch : c_drain;
            else if (imem_rsp_valid) w_state_next = w_req_fire ? c_wait : c_fetch;
         end
         c_drain: begin
            if (imem_rsp_valid) w_state_next = c_fetch;
         end
         default: w_state_next = c_fetch;
      endcase
   end

   // Fetch PC (redirect wins over sequential advance) and outstanding PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc_f   <= RESET_PC;
         r_req_pc <= '0;
      end else begin
         if (w_redirect)      r_pc_f <= BranchTargetExec;
         else if (w_req_fire) r_pc_f <= r_pc_f + c_four;
         if (w_req_fire)      r_req_pc <= r_pc_f;
      end
   end

   // Skid buffer: catch a response Decode cannot take, release when it can
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skid_valid <= 1'b0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
      end else if (w_redirect) begin
         r_skid_valid <= 1'b0;
      end else if (w_fill_skid) begin
         r_skid_valid <= 1'b1;
         r_skid_instr <= imem_rsp_data;
         r_skid_pc    <= r_req_pc;
      end else if (w_drain_skid) begin
         r_skid_valid <= 1'b0;
      end
   end

   // IF/ID register: flush beats stall beats load; idle loads a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         InstrDec   <= NOP;
         PCDec      <= '0;
         PCPlus4Dec <= '0;
         ValidDec   <= 1'b0;
      end else if (FlushDecode) begin
         InstrDec   <= NOP;
         PCDec      <= '0;
         PCPlus4Dec <= '0;
         ValidDec   <= 1'b0;
      end else if (!StallDecode) begin
         if (w_load_rsp) begin
            InstrDec   <= imem_rsp_data;
            PCDec      <= r_req_pc;
            PCPlus4Dec <= r_req_pc + c_four;
            ValidDec   <= 1'b1;
         end else if (w_drain_skid) begin
            InstrDec   <= r_skid_instr;
            PCDec      <= r_skid_pc;
            PCPlus4Dec <= r_skid_pc + c_four;
            ValidDec   <= 1'b1;
         end else begin
            InstrDec   <= NOP;
            PCDec      <= '0;
            PCPlus4Dec <= '0;
            ValidDec   <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_decode_stage
//  Description : Directed self-checking bench for fetch_decode_stage with a
//                behavioural instruction memory of programmable latency that
//                returns addr ^ 32'hA5A5_0000.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_stage;

   localparam logic [31:0] c_nop  = 32'h0000_0013;
   localparam logic [31:0] c_mask = 32'hA5A5_0000;

   logic        clk;
   logic        rst_n;
   logic        StallFetch;
   logic        StallDecode;
   logic        FlushDecode;
   logic        ProgramCounterSourceExec;
   logic [31:0] BranchTargetExec;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] InstrDec;
   logic [31:0] PCDec;
   logic [31:0] PCPlus4Dec;
   logic        ValidDec;

   int          n_checks;
   int          n_errors;

   // Memory model state
   int          lat;
   logic        pending;
   int          rem;
   logic [31:0] paddr;

   fetch_decode_stage #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .NOP      (32'h0000_0013)
   ) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .StallFetch               (StallFetch),
      .StallDecode              (StallDecode),
      .FlushDecode              (FlushDecode),
      .ProgramCounterSourceExec (ProgramCounterSourceExec),
      .BranchTargetExec         (BranchTargetExec),
      .imem_req_valid           (imem_req_valid),
      .imem_req_ready           (imem_req_ready),
      .imem_req_addr            (imem_req_addr),
      .imem_rsp_valid           (imem_rsp_valid),
      .imem_rsp_data            (imem_rsp_data),
      .InstrDec                 (InstrDec),
      .PCDec                    (PCDec),
      .PCPlus4Dec               (PCPlus4Dec),
      .ValidDec                 (ValidDec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock: sample acceptance, clock edge, update memory, park at negedge
   task automatic step();
      logic        acc;
      logic [31:0] a;
      #1;
      acc = imem_req_valid & imem_req_ready;
      a   = imem_req_addr;
      @(posedge clk);
      #1;
      if (imem_rsp_valid) begin
         pending        = 1'b0;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end else if (pending) begin
         rem = rem - 1;
      end
      if (acc) begin
         pending = 1'b1;
         rem     = lat - 1;
         paddr   = a;
      end
      if (pending && rem == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = paddr ^ c_mask;
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      lat = 1; pending = 1'b0; rem = 0; paddr = '0;
      rst_n = 1'b0;
      StallFetch = 1'b0; StallDecode = 1'b0; FlushDecode = 1'b0;
      ProgramCounterSourceExec = 1'b0; BranchTargetExec = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'hDEAD_BEEF;

      repeat (2) @(negedge clk);
      check("rst_instr",  InstrDec, c_nop);
      check("rst_pc",     PCDec, 32'h0);
      check("rst_pc4",    PCPlus4Dec, 32'h0);
      check("rst_valid",  {31'b0, ValidDec}, 32'd0);
      check("rst_req",    {31'b0, imem_req_valid}, 32'd0);

      // Streaming at full rate
      rst_n = 1'b1; #1;
      check("c0_req",  {31'b0, imem_req_valid}, 32'd1);
      check("c0_addr", imem_req_addr, 32'h0);
      step();
      check("c1_addr", imem_req_addr, 32'h4);
      step();
      check("c2_pc",    PCDec, 32'h0);
      check("c2_valid", {31'b0, ValidDec}, 32'd1);
      check("c2_instr", InstrDec, 32'hA5A5_0000);
      check("c2_pc4",   PCPlus4Dec, 32'h4);
      check("c2_addr",  imem_req_addr, 32'h8);
      step();
      check("c3_pc",    PCDec, 32'h4);
      check("c3_valid", {31'b0, ValidDec}, 32'd1);

      // Decode stall while response for 0x8 lands -> skid
      StallDecode = 1'b1; #1;
      check("c3_stall_req", {31'b0, imem_req_valid}, 32'd0);
      step();
      check("c4_pc",    PCDec, 32'h4);
      check("c4_instr", InstrDec, 32'hA5A5_0004);
      check("c4_req",   {31'b0, imem_req_valid}, 32'd0);
      step();
      check("c5_pc",    PCDec, 32'h4);
      step();
      StallDecode = 1'b0; #1;
      check("c6_req",   {31'b0, imem_req_valid}, 32'd0);
      check("c6_pc",    PCDec, 32'h4);
      step();
      check("c7_pc",    PCDec, 32'h8);
      check("c7_instr", InstrDec, 32'hA5A5_0008);
      check("c7_valid", {31'b0, ValidDec}, 32'd1);
      check("c7_req",   {31'b0, imem_req_valid}, 32'd1);
      check("c7_addr",  imem_req_addr, 32'hC);
      step();
      check("c8_addr",  imem_req_addr, 32'h10);

      // Redirect while 0x10 outstanding with slow memory
      lat = 3;
      step();
      check("c9_pc",  PCDec, 32'hC);
      check("c9_req", {31'b0, imem_req_valid}, 32'd0);
      ProgramCounterSourceExec = 1'b1; BranchTargetExec = 32'h100; #1;
      check("c9_redir_req", {31'b0, imem_req_valid}, 32'd0);
      step();
      ProgramCounterSourceExec = 1'b0; #1;
      check("c10_req",   {31'b0, imem_req_valid}, 32'd0);
      check("c10_valid", {31'b0, ValidDec}, 32'd0);
      step();
      check("c11_req",   {31'b0, imem_req_valid}, 32'd0);
      check("c11_valid", {31'b0, ValidDec}, 32'd0);
      step();
      check("c12_req",   {31'b0, imem_req_valid}, 32'd1);
      check("c12_addr",  imem_req_addr, 32'h100);
      check("c12_valid", {31'b0, ValidDec}, 32'd0);
      step();
      check("c13_valid", {31'b0, ValidDec}, 32'd0);
      check("c13_req",   {31'b0, imem_req_valid}, 32'd0);
      step();
      step();
      check("c15_req",  {31'b0, imem_req_valid}, 32'd1);
      check("c15_addr", imem_req_addr, 32'h104);
      step();
      check("c16_pc",    PCDec, 32'h100);
      check("c16_instr", InstrDec, 32'hA5A5_0100);

      // Flush together with stall
      FlushDecode = 1'b1; StallDecode = 1'b1;
      step();
      check("c17_instr", InstrDec, c_nop);
      check("c17_valid", {31'b0, ValidDec}, 32'd0);
      FlushDecode = 1'b0; StallDecode = 1'b0; lat = 1;
      step();
      step();
      check("c19_pc",    PCDec, 32'h104);
      check("c19_instr", InstrDec, 32'hA5A5_0104);

      // StallFetch and redirect together; target near the top of memory
      StallFetch = 1'b1; ProgramCounterSourceExec = 1'b1;
      BranchTargetExec = 32'hFFFF_FFFC; #1;
      check("c19_req", {31'b0, imem_req_valid}, 32'd0);
      step();
      ProgramCounterSourceExec = 1'b0; #1;
      check("c20_req",   {31'b0, imem_req_valid}, 32'd0);
      check("c20_valid", {31'b0, ValidDec}, 32'd0);
      step();
      StallFetch = 1'b0; #1;
      check("c21_req",  {31'b0, imem_req_valid}, 32'd1);
      check("c21_addr", imem_req_addr, 32'hFFFF_FFFC);
      step();
      check("c22_addr", imem_req_addr, 32'h0);
      step();
      check("c23_pc",    PCDec, 32'hFFFF_FFFC);
      check("c23_pc4",   PCPlus4Dec, 32'h0);
      check("c23_instr", InstrDec, 32'h5A5A_FFFC);
      check("c23_addr",  imem_req_addr, 32'h4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

Fetch unit plus IF/ID pipeline register that consumes the stall, flush and redirect controls produced by the hazard unit. It issues PC-ordered requests to instruction memory over a valid/ready request channel with a valid-only response. Returned instructions go into the Decode-stage register. A one-entry skid buffer absorbs a response that lands while Decode is stalled.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0013, instruction word driven for bubbles (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- StallFetch  in  1  hold PC; issue no new request
- StallDecode  in  1  hold IF/ID contents
- FlushDecode  in  1  replace IF/ID with bubble
- ProgramCounterSourceExec  in  1  taken branch/jump in Execute (redirect)
- BranchTargetExec  in  XLEN  redirect address
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  request address (current PC_F)
- imem_rsp_valid  in  1  response valid, one per accepted request, in order, ≥1 cycle after acceptance
- imem_rsp_data  in  XLEN  instruction word
- InstrDec  out  XLEN  IF/ID instruction
- PCDec  out  XLEN  IF/ID PC
- PCPlus4Dec  out  XLEN  IF/ID PC+4
- ValidDec  out  1  IF/ID holds a real instruction

## Operation
- At most one request outstanding. reqPC register records the PC of the outstanding request.
- States:
  - FETCH: no request outstanding.
  - WAIT: request outstanding, response wanted.
  - DRAIN: request outstanding, response to be discarded.
- Request issue:
  - imem_req_valid = rst_n & !StallFetch & !ProgramCounterSourceExec & skid empty & (state==FETCH | (state==WAIT & imem_rsp_valid & response goes direct)).
  - "Direct" means !StallDecode & skid empty.
  - On acceptance: reqPC←PC_F, PC_F←PC_F+4 (mod 2^XLEN), state←WAIT.
- Response in WAIT:
  - Goes direct if !StallDecode & skid empty: IF/ID←{data, reqPC, reqPC+4, valid=1}.
  - Otherwise it is written to the skid buffer.
  - State→FETCH, or stays WAIT if a new request is accepted in the same cycle.
- Skid drain: when !StallDecode and the skid is full, IF/ID←skid entry and the skid empties. A new response cannot arrive then, because no request issues while the skid is full.
- IF/ID update when !StallDecode and nothing to load: load a bubble (NOP, valid=0).
- FlushDecode: IF/ID←bubble. Overrides StallDecode and any load.
- Redirect (ProgramCounterSourceExec=1):
  - PC_F←BranchTargetExec and the skid is cleared. This overrides StallFetch.
  - No request is issued that cycle.
  - If state==WAIT and no response arrives this cycle, state→DRAIN.
  - If a response arrives this cycle, it is discarded and state→FETCH.
- DRAIN: the next imem_rsp_valid is discarded, then state→FETCH. A further redirect in DRAIN only updates PC_F.
- Illegal state encoding recovers to FETCH.

## Timing
- Reset (rst_n low, asynchronous):
  - PC_F=RESET_PC, state=FETCH, skid empty, reqPC=0.
  - InstrDec=NOP, PCDec=0, PCPlus4Dec=0, ValidDec=0.
  - imem_req_valid=0.
- Reset asserted mid-transaction abandons the outstanding request. The environment must not deliver its response after reset release.
- Best-case latency, with ready=1 and the response one cycle after acceptance:
  - Request accepted in cycle t, response in t+1, InstrDec visible in cycle t+2.
  - Sustained throughput is 1 instruction/cycle.
- All outputs except imem_req_valid and imem_req_addr are registered.
- imem_req_valid is combinational from state, controls and imem_rsp_valid.
- imem_req_addr = PC_F, stable while valid & !ready.
- Priority in IF/ID: FlushDecode > StallDecode > load.
- Priority in PC_F: redirect > accepted request > hold.
- Once asserted, imem_req_valid may drop only because of StallFetch, redirect or StallDecode. Memory must tolerate the withdrawal.

## Test plan
- Reset release, ready=1, 1-cycle memory returning addr^32'hA5A5_0000:
  - Requests go to 0x0, 0x4, 0x8 on consecutive cycles.
  - PCDec follows 0x0, 0x4, 0x8 starting cycle 2, with ValidDec=1 continuously.
- StallDecode held 3 cycles while the response for 0x8 arrives:
  - Response for 0x8 is held in the skid and no new request issues.
  - InstrDec stays 0x4's word.
  - After release, 0x8 loads the next cycle and requests resume at 0xC.
- Redirect to 0x100 while the request for 0x10 is in WAIT with a 3-cycle memory:
  - Response for 0x10 is discarded (DRAIN).
  - Next request address is 0x100.
  - PCDec never shows 0x10.
- FlushDecode and StallDecode asserted together: IF/ID becomes NOP, ValidDec=0, PCDec=0 retained-value irrelevant.
- StallFetch with redirect in the same cycle: PC_F takes BranchTargetExec and no request that cycle. The next request is to the target once StallFetch drops.
- PC_F=32'hFFFF_FFFC accepted: the next request address wraps to 0x0000_0000.
